// File: rtl/reset_sequencer.sv
// Lock-driven reset sequencer: holds the PLL in reset, waits for stable lock,
// then releases the domain resets one by one, retrying the PLL on lock timeout.
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int NUM_LOCKS      = 2,
    parameter int NUM_RST_OUT    = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 60000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                   drp_and_sys_clk,
    input  logic                   g_reset,
    input  logic [NUM_LOCKS-1:0]   lock_in,
    input  logic                   status_clear,
    output logic                   pll_reset,
    output logic [NUM_RST_OUT-1:0] rst_out,
    output logic                   all_ready,
    output logic                   lock_lost_sticky,
    output logic [3:0]             retry_count,
    output logic                   fault
);

    localparam logic [2:0] S_HOLD      = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_PLL_RST   = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    localparam int CNT_MAX_A = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CNT_MAX   = (LOCK_TIMEOUT > CNT_MAX_A) ? LOCK_TIMEOUT : CNT_MAX_A;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int STB_W     = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(STRETCH_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    logic [SYNC_STAGES-1:0][NUM_LOCKS-1:0] sync_q;
    logic                   locked;
    logic [2:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [STB_W-1:0]       stable_cnt;
    logic [NUM_RST_OUT-1:0] rst_shift;
    logic [3:0]             retry_next;

    // NOTE: synchroniser flops are reset too, so a stale "locked" can never
    // survive g_reset and short-circuit the stable-lock count.
    always_ff @(posedge drp_and_sys_clk or posedge g_reset) begin
        if (g_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
        end
    end

    assign locked     = &sync_q[SYNC_STAGES-1];
    // Clearing from the LSB upward makes out-of-order release impossible.
    assign rst_shift  = rst_out << 1;
    assign retry_next = retry_count + 4'd1;

    // NOTE: all state uses non-blocking assignments; where a register is
    // written twice in one pass, the later assignment is the one that lands.
    always_ff @(posedge drp_and_sys_clk or posedge g_reset) begin
        if (g_reset) begin
            state            <= S_HOLD;
            cnt              <= '0;
            stable_cnt       <= '0;
            pll_reset        <= 1'b1;
            rst_out          <= '1;
            all_ready        <= 1'b0;
            lock_lost_sticky <= 1'b0;
            retry_count      <= 4'd0;
            fault            <= 1'b0;
        end else begin
            if (status_clear) begin
                lock_lost_sticky <= 1'b0;
            end

            if ((state == S_RELEASE || state == S_RUN) && !locked) begin
                // Lock lost: a set here overrides a same-cycle status_clear.
                state            <= S_WAIT_LOCK;
                cnt              <= '0;
                stable_cnt       <= '0;
                rst_out          <= '1;
                all_ready        <= 1'b0;
                lock_lost_sticky <= 1'b1;
            end else begin
                case (state)
                    S_HOLD, S_PLL_RST: begin
                        if (cnt == STRETCH_LAST) begin
                            state      <= S_WAIT_LOCK;
                            pll_reset  <= 1'b0;
                            cnt        <= '0;
                            stable_cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    S_WAIT_LOCK: begin
                        if (locked && stable_cnt == STABLE_LAST) begin
                            rst_out    <= rst_shift;
                            cnt        <= '0;
                            stable_cnt <= '0;
                            if (rst_shift == '0) begin
                                state       <= S_RUN;
                                all_ready   <= 1'b1;
                                retry_count <= 4'd0;
                            end else begin
                                state <= S_RELEASE;
                            end
                        end else if (cnt == TIMEOUT_LAST) begin
                            cnt         <= '0;
                            stable_cnt  <= '0;
                            retry_count <= retry_next;
                            if (retry_next == RETRY_LIMIT) begin
                                state <= S_FAULT;
                                fault <= 1'b1;
                            end else begin
                                state     <= S_PLL_RST;
                                pll_reset <= 1'b1;
                            end
                        end else begin
                            cnt        <= cnt + CNT_W'(1);
                            stable_cnt <= locked ? stable_cnt + STB_W'(1) : '0;
                        end
                    end

                    S_RELEASE: begin
                        if (cnt == STAGGER_LAST) begin
                            rst_out <= rst_shift;
                            cnt     <= '0;
                            if (rst_shift == '0) begin
                                state       <= S_RUN;
                                all_ready   <= 1'b1;
                                retry_count <= 4'd0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    S_RUN: begin
                    end

                    S_FAULT: begin
                        fault     <= 1'b1;
                        pll_reset <= 1'b0;
                        rst_out   <= '1;
                        all_ready <= 1'b0;
                    end

                    default: begin
                        state      <= S_HOLD;
                        cnt        <= '0;
                        stable_cnt <= '0;
                        pll_reset  <= 1'b1;
                        rst_out    <= '1;
                        all_ready  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: bring-up, lock glitch, lock loss,
// sticky set/clear race, asynchronous reset mid-release and timeout to fault.
`timescale 1ns/1ps

module tb_reset_sequencer;

    localparam int NUM_LOCKS   = 2;
    localparam int NUM_RST_OUT = 3;

    logic                   clk = 1'b0;
    logic                   g_reset;
    logic [NUM_LOCKS-1:0]   lock_in;
    logic                   status_clear;
    logic                   pll_reset;
    logic [NUM_RST_OUT-1:0] rst_out;
    logic                   all_ready;
    logic                   lock_lost_sticky;
    logic [3:0]             retry_count;
    logic                   fault;

    int total = 0;
    int bad   = 0;

    reset_sequencer #(
        .NUM_LOCKS     (NUM_LOCKS),
        .NUM_RST_OUT   (NUM_RST_OUT),
        .SYNC_STAGES   (2),
        .STRETCH_CYCLES(4),
        .STAGGER_CYCLES(2),
        .LOCK_TIMEOUT  (50),
        .MAX_RETRY     (2)
    ) dut (
        .drp_and_sys_clk (clk),
        .g_reset         (g_reset),
        .lock_in         (lock_in),
        .status_clear    (status_clear),
        .pll_reset       (pll_reset),
        .rst_out         (rst_out),
        .all_ready       (all_ready),
        .lock_lost_sticky(lock_lost_sticky),
        .retry_count     (retry_count),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, then settle 1 ns so outputs are sampled clear of the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        g_reset      = 1'b1;
        lock_in      = 2'b11;
        status_clear = 1'b0;

        // Reset state
        #240;
        check("rst_pll",    pll_reset,        1);
        check("rst_rstout", rst_out,          3'b111);
        check("rst_ready",  all_ready,        0);
        check("rst_sticky", lock_lost_sticky, 0);
        check("rst_retry",  retry_count,      0);
        check("rst_fault",  fault,            0);

        // Nominal bring-up, g_reset released between edges; E1 is the edge at 245 ns
        #3 g_reset = 1'b0;
        step(3);  check("nom_e3_pll",    pll_reset, 1);
        step(1);  check("nom_e4_pll",    pll_reset, 0);
                  check("nom_e4_rst",    rst_out,   3'b111);
        step(3);  check("nom_e7_rst",    rst_out,   3'b111);
        step(1);  check("nom_e8_rst",    rst_out,   3'b110);
        step(1);  check("nom_e9_rst",    rst_out,   3'b110);
        step(1);  check("nom_e10_rst",   rst_out,   3'b100);
                  check("nom_e10_ready", all_ready, 0);
        step(1);  check("nom_e11_rst",   rst_out,   3'b100);
        step(1);  check("nom_e12_rst",   rst_out,   3'b000);
                  check("nom_e12_ready", all_ready, 1);
                  check("nom_e12_retry", retry_count, 0);
                  check("nom_e12_stky",  lock_lost_sticky, 0);

        // Lock loss in RUN: seen on the third edge after lock_in drops
        lock_in = 2'b10;
        step(2);  check("loss_e14_rst",   rst_out,   3'b000);
                  check("loss_e14_ready", all_ready, 1);
        step(1);  check("loss_e15_rst",   rst_out,   3'b111);
                  check("loss_e15_ready", all_ready, 0);
                  check("loss_e15_stky",  lock_lost_sticky, 1);
                  check("loss_e15_pll",   pll_reset, 0);
        lock_in = 2'b11;
        step(5);  check("rerel_e20_rst",  rst_out,   3'b111);
        step(1);  check("rerel_e21_rst",  rst_out,   3'b110);
        step(4);  check("rerel_e25_rst",  rst_out,   3'b000);
                  check("rerel_e25_rdy",  all_ready, 1);
                  check("rerel_e25_stky", lock_lost_sticky, 1);
        status_clear = 1'b1;
        step(1);  status_clear = 1'b0;
                  check("clear_e26_stky", lock_lost_sticky, 0);

        // Set and clear on the same edge: set wins
        lock_in = 2'b01;
        step(2);  check("race_e28_stky", lock_lost_sticky, 0);
                  check("race_e28_rst",  rst_out, 3'b000);
        status_clear = 1'b1;
        step(1);  status_clear = 1'b0;
                  check("race_e29_stky", lock_lost_sticky, 1);
                  check("race_e29_rst",  rst_out, 3'b111);
        lock_in = 2'b11;
        step(8);  check("race_e37_rst",  rst_out, 3'b100);

        // Asynchronous reset mid-RELEASE, no clock edge in between
        #2 g_reset = 1'b1;
        #1;       check("arst_rst",   rst_out,   3'b111);
                  check("arst_pll",   pll_reset, 1);
                  check("arst_ready", all_ready, 0);
                  check("arst_stky",  lock_lost_sticky, 0);
        step(2);  check("arst_hold_pll", pll_reset, 1);
        #3 g_reset = 1'b0;

        // Restart from HOLD with a one-cycle glitch on lock_in[1] during WAIT_LOCK
        step(3);  check("glt_g3_pll", pll_reset, 1);
        step(1);  check("glt_g4_pll", pll_reset, 0);
        step(1);  lock_in = 2'b01;
        step(1);  lock_in = 2'b11;
        step(5);  check("glt_g11_rst",   rst_out, 3'b111);
                  check("glt_g11_retry", retry_count, 0);
        step(1);  check("glt_g12_rst",   rst_out, 3'b110);
                  check("glt_g12_retry", retry_count, 0);

        // Timeout retries until FAULT with one lock permanently low
        g_reset = 1'b1;
        lock_in = 2'b01;
        step(2);
        #3 g_reset = 1'b0;
        step(4);  check("to_f4_pll",    pll_reset, 0);
        step(49); check("to_f53_pll",   pll_reset, 0);
                  check("to_f53_retry", retry_count, 0);
        step(1);  check("to_f54_pll",   pll_reset, 1);
                  check("to_f54_retry", retry_count, 1);
                  check("to_f54_fault", fault, 0);
        step(3);  check("to_f57_pll",   pll_reset, 1);
        step(1);  check("to_f58_pll",   pll_reset, 0);
        step(49); check("to_f107_fault", fault, 0);
                  check("to_f107_retry", retry_count, 1);
                  check("to_f107_pll",   pll_reset, 0);
        step(1);  check("to_f108_fault", fault, 1);
                  check("to_f108_retry", retry_count, 2);
                  check("to_f108_pll",   pll_reset, 0);
                  check("to_f108_rst",   rst_out, 3'b111);
                  check("to_f108_ready", all_ready, 0);

        // FAULT persists even once lock returns
        lock_in = 2'b11;
        step(20); check("flt_hold_fault", fault, 1);
                  check("flt_hold_rst",   rst_out, 3'b111);
                  check("flt_hold_pll",   pll_reset, 0);
                  check("flt_hold_retry", retry_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
